// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM read arbiter: shares one VRAM read port between the background
// fetcher and the sprite fetcher. Sprite requests win; one access in flight.
module ppu_vram_arbiter #(
  parameter int          TIMEOUT  = 8,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic        bg_req_in,
  input  logic [15:0] bg_addr_in,
  output logic [7:0]  bg_data_out,
  output logic        bg_data_valid_out,
  input  logic        sprite_req_in,
  input  logic [15:0] sprite_addr_in,
  output logic [7:0]  sprite_data_out,
  output logic        sprite_data_valid_out,
  input  logic        sprite_detected_in,
  output logic        mem_free_out,
  output logic [15:0] vram_addr_out,
  output logic        vram_rd_out,
  input  logic [7:0]  vram_data_in,
  input  logic        vram_valid_in,
  output logic        timeout_err_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Counter only needs to reach TIMEOUT-1.
  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic          owner_spr_q;   // 1 = sprite owns the current access
  logic [15:0]   addr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    bg_data_q;
  logic          bg_valid_q;
  logic [7:0]    spr_data_q;
  logic          spr_valid_q;
  logic          rd_q;
  logic          mem_free_q;
  logic          err_q;

  // Arbitration FSM with all outputs registered; valid and read strobes
  // default low each cycle so they can only ever pulse for one cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      owner_spr_q <= 1'b0;
      addr_q      <= 16'h0000;
      cnt_q       <= '0;
      bg_data_q   <= 8'h00;
      bg_valid_q  <= 1'b0;
      spr_data_q  <= 8'h00;
      spr_valid_q <= 1'b0;
      rd_q        <= 1'b0;
      mem_free_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      bg_valid_q  <= 1'b0;
      spr_valid_q <= 1'b0;
      rd_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tclk_in) begin
            if (sprite_req_in) begin
              addr_q      <= sprite_addr_in;
              owner_spr_q <= 1'b1;
              state_q     <= ST_ISSUE;
              rd_q        <= 1'b1;
              mem_free_q  <= 1'b0;
            end else if (bg_req_in && !sprite_detected_in) begin
              addr_q      <= bg_addr_in;
              owner_spr_q <= 1'b0;
              state_q     <= ST_ISSUE;
              rd_q        <= 1'b1;
              mem_free_q  <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          // Real data beats the timeout when both land on the same cycle.
          if (vram_valid_in) begin
            if (owner_spr_q) begin
              spr_data_q  <= vram_data_in;
              spr_valid_q <= 1'b1;
            end else begin
              bg_data_q  <= vram_data_in;
              bg_valid_q <= 1'b1;
            end
            state_q    <= ST_IDLE;
            mem_free_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            if (owner_spr_q) begin
              spr_data_q  <= OPEN_BUS;
              spr_valid_q <= 1'b1;
            end else begin
              bg_data_q  <= OPEN_BUS;
              bg_valid_q <= 1'b1;
            end
            err_q      <= 1'b1;
            state_q    <= ST_IDLE;
            mem_free_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_free_q <= 1'b1;
        end
      endcase
    end
  end

  assign bg_data_out           = bg_data_q;
  assign bg_data_valid_out     = bg_valid_q;
  assign sprite_data_out       = spr_data_q;
  assign sprite_data_valid_out = spr_valid_q;
  assign mem_free_out          = mem_free_q;
  assign vram_addr_out         = addr_q;
  assign vram_rd_out           = rd_q;
  assign timeout_err_out       = err_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: scoreboard queues of expected read addresses
// and per-requester data, drained by a monitor on the falling clock edge.
module tb_ppu_vram_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        tclk_in;
  logic        bg_req_in;
  logic [15:0] bg_addr_in;
  logic [7:0]  bg_data_out;
  logic        bg_data_valid_out;
  logic        sprite_req_in;
  logic [15:0] sprite_addr_in;
  logic [7:0]  sprite_data_out;
  logic        sprite_data_valid_out;
  logic        sprite_detected_in;
  logic        mem_free_out;
  logic [15:0] vram_addr_out;
  logic        vram_rd_out;
  logic [7:0]  vram_data_in;
  logic        vram_valid_in;
  logic        timeout_err_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_bg_q[$];
  logic [7:0]  exp_spr_q[$];

  ppu_vram_arbiter #(.TIMEOUT(TIMEOUT), .OPEN_BUS(8'hFF)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .tclk_in               (tclk_in),
    .bg_req_in             (bg_req_in),
    .bg_addr_in            (bg_addr_in),
    .bg_data_out           (bg_data_out),
    .bg_data_valid_out     (bg_data_valid_out),
    .sprite_req_in         (sprite_req_in),
    .sprite_addr_in        (sprite_addr_in),
    .sprite_data_out       (sprite_data_out),
    .sprite_data_valid_out (sprite_data_valid_out),
    .sprite_detected_in    (sprite_detected_in),
    .mem_free_out          (mem_free_out),
    .vram_addr_out         (vram_addr_out),
    .vram_rd_out           (vram_rd_out),
    .vram_data_in          (vram_data_in),
    .vram_valid_in         (vram_valid_in),
    .timeout_err_out       (timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Scoreboard monitor: every read strobe and data pulse must match a queued expectation.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (vram_rd_out) begin
        if (exp_rd_q.size() == 0) check_eq("rd_unexpected", 32'(vram_rd_out), 32'd0);
        else check_eq("rd_addr", 32'(vram_addr_out), 32'(exp_rd_q.pop_front()));
      end
      if (bg_data_valid_out) begin
        if (exp_bg_q.size() == 0) check_eq("bg_unexpected", 32'(bg_data_valid_out), 32'd0);
        else check_eq("bg_data", 32'(bg_data_out), 32'(exp_bg_q.pop_front()));
      end
      if (sprite_data_valid_out) begin
        if (exp_spr_q.size() == 0) check_eq("spr_unexpected", 32'(sprite_data_valid_out), 32'd0);
        else check_eq("spr_data", 32'(sprite_data_out), 32'(exp_spr_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe();
    tclk_in = 1'b1;
    tick();
    tclk_in = 1'b0;
  endtask

  // Called right after a granting strobe: the read strobe must be in this cycle.
  task automatic expect_rd(input string tag);
    @(negedge clk_in);
    check_eq({tag, "_rd"}, 32'(vram_rd_out), 32'd1);
    check_eq({tag, "_busy"}, 32'(mem_free_out), 32'd0);
  endtask

  // From the ISSUE negedge: raise vram_valid_in during WAIT cycle d.
  task automatic serve(input int d, input logic [7:0] data);
    repeat (d) tick();
    vram_valid_in = 1'b1;
    vram_data_in  = data;
    tick();
    vram_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_in);
    while (!mem_free_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check_eq({tag, "_free"}, 32'(mem_free_out), 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_rdq"},  32'(exp_rd_q.size()),  32'd0);
    check_eq({tag, "_bgq"},  32'(exp_bg_q.size()),  32'd0);
    check_eq({tag, "_sprq"}, 32'(exp_spr_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst_in = 1'b1; tclk_in = 1'b0; bg_req_in = 1'b0; bg_addr_in = 16'h0;
    sprite_req_in = 1'b0; sprite_addr_in = 16'h0; sprite_detected_in = 1'b0;
    vram_data_in = 8'h00; vram_valid_in = 1'b0;
    repeat (2) tick();
    @(negedge clk_in);
    check_eq("rst_free",   32'(mem_free_out),          32'd1);
    check_eq("rst_rd",     32'(vram_rd_out),           32'd0);
    check_eq("rst_addr",   32'(vram_addr_out),         32'd0);
    check_eq("rst_bgv",    32'(bg_data_valid_out),     32'd0);
    check_eq("rst_sprv",   32'(sprite_data_valid_out), 32'd0);
    check_eq("rst_bgd",    32'(bg_data_out),           32'd0);
    check_eq("rst_sprd",   32'(sprite_data_out),       32'd0);
    check_eq("rst_err",    32'(timeout_err_out),       32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Background only.
    bg_req_in = 1'b1; bg_addr_in = 16'h8010;
    exp_rd_q.push_back(16'h8010); exp_bg_q.push_back(8'h3C);
    strobe();
    expect_rd("bg1");
    serve(2, 8'h3C);
    wait_idle("bg1");
    tick(); bg_req_in = 1'b0;
    repeat (3) tick();
    check_drained("bg1");

    // Contention: sprite first, background on the next strobe.
    sprite_req_in = 1'b1; sprite_addr_in = 16'h8200;
    bg_req_in = 1'b1; bg_addr_in = 16'h9800;
    exp_rd_q.push_back(16'h8200); exp_rd_q.push_back(16'h9800);
    exp_spr_q.push_back(8'hA5); exp_bg_q.push_back(8'h5A);
    strobe();
    expect_rd("cont_spr");
    serve(2, 8'hA5);
    wait_idle("cont_spr");
    tick(); sprite_req_in = 1'b0;
    strobe();
    expect_rd("cont_bg");
    serve(1, 8'h5A);
    wait_idle("cont_bg");
    tick(); bg_req_in = 1'b0;
    repeat (3) tick();
    check_drained("cont");

    // Blocked by sprite_detected, then released.
    sprite_detected_in = 1'b1; bg_req_in = 1'b1; bg_addr_in = 16'h1234;
    repeat (10) begin
      strobe();
      tick();
    end
    @(negedge clk_in);
    check_eq("blk_free", 32'(mem_free_out), 32'd1);
    tick();
    sprite_detected_in = 1'b0;
    exp_rd_q.push_back(16'h1234); exp_bg_q.push_back(8'h77);
    strobe();
    expect_rd("blk");
    serve(3, 8'h77);
    wait_idle("blk");
    tick(); bg_req_in = 1'b0;
    repeat (3) tick();
    check_drained("blk");

    // Valid on the last WAIT cycle: data wins, no error.
    sprite_req_in = 1'b1; sprite_addr_in = 16'h0ABC;
    exp_rd_q.push_back(16'h0ABC); exp_spr_q.push_back(8'hC3);
    strobe();
    expect_rd("edge");
    serve(TIMEOUT, 8'hC3);
    wait_idle("edge");
    check_eq("edge_err", 32'(timeout_err_out), 32'd0);
    tick(); sprite_req_in = 1'b0;
    repeat (3) tick();
    check_drained("edge");

    // Timeout: no valid ever; open bus delivered, sticky error.
    bg_req_in = 1'b1; bg_addr_in = 16'h4000;
    exp_rd_q.push_back(16'h4000); exp_bg_q.push_back(8'hFF);
    strobe();
    expect_rd("to");
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!bg_data_valid_out && n < 40);
    check_eq("to_latency", 32'(n), 32'(TIMEOUT + 1));
    check_eq("to_err", 32'(timeout_err_out), 32'd1);
    tick(); bg_req_in = 1'b0;
    sprite_req_in = 1'b1; sprite_addr_in = 16'h0101;
    exp_rd_q.push_back(16'h0101); exp_spr_q.push_back(8'h11);
    strobe();
    expect_rd("to2");
    serve(1, 8'h11);
    wait_idle("to2");
    check_eq("to_sticky", 32'(timeout_err_out), 32'd1);
    tick(); sprite_req_in = 1'b0;
    repeat (3) tick();
    check_drained("to");

    // Reset in WAIT: access discarded, later valid ignored.
    sprite_req_in = 1'b1; sprite_addr_in = 16'h2222;
    exp_rd_q.push_back(16'h2222);
    strobe();
    expect_rd("rw");
    tick(); tick();
    rst_in = 1'b1; sprite_req_in = 1'b0;
    tick();
    rst_in = 1'b0;
    vram_valid_in = 1'b1; vram_data_in = 8'h55;
    tick();
    vram_valid_in = 1'b0;
    @(negedge clk_in);
    check_eq("rw_free", 32'(mem_free_out), 32'd1);
    check_eq("rw_err",  32'(timeout_err_out), 32'd0);
    check_eq("rw_sprd", 32'(sprite_data_out), 32'd0);
    repeat (3) tick();
    bg_req_in = 1'b1; bg_addr_in = 16'h3333;
    exp_rd_q.push_back(16'h3333); exp_bg_q.push_back(8'h99);
    strobe();
    expect_rd("rw2");
    serve(2, 8'h99);
    wait_idle("rw2");
    tick(); bg_req_in = 1'b0;
    repeat (3) tick();
    check_drained("rw");

    // Request withdrawn after ISSUE: still completes once, no re-grant.
    bg_req_in = 1'b1; bg_addr_in = 16'h5555;
    exp_rd_q.push_back(16'h5555); exp_bg_q.push_back(8'h6E);
    strobe();
    expect_rd("wd");
    tick();
    bg_req_in = 1'b0;
    tick();
    vram_valid_in = 1'b1; vram_data_in = 8'h6E;
    tick();
    vram_valid_in = 1'b0;
    wait_idle("wd");
    repeat (3) begin
      strobe();
      tick();
    end
    check_drained("wd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
